// File: rtl/id_stage_pkg.sv
// Purpose: shared constants and types for the decode stage.
//   Holds the opcode map, the ALU command encodings, the instruction field
//   positions, and the ID/EX payload struct.
// Ports: none (package).
package id_stage_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned ALU_W     = 4;
    localparam int unsigned IMM_W     = 16;

    // Instruction field bit positions
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned SRC1_MSB = 25;
    localparam int unsigned SRC1_LSB = 21;
    localparam int unsigned SRC2_MSB = 20;
    localparam int unsigned SRC2_LSB = 16;
    localparam int unsigned RDST_MSB = 15;
    localparam int unsigned RDST_LSB = 11;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned IMM_LSB  = 0;

    // Opcodes
    localparam logic [OP_W-1:0] OP_ADD  = 6'b000001;
    localparam logic [OP_W-1:0] OP_SUB  = 6'b000011;
    localparam logic [OP_W-1:0] OP_AND  = 6'b000101;
    localparam logic [OP_W-1:0] OP_OR   = 6'b000110;
    localparam logic [OP_W-1:0] OP_NOR  = 6'b000111;
    localparam logic [OP_W-1:0] OP_XOR  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLA  = 6'b001001;
    localparam logic [OP_W-1:0] OP_SLL  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SRA  = 6'b001011;
    localparam logic [OP_W-1:0] OP_SRL  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUBI = 6'b100001;
    localparam logic [OP_W-1:0] OP_LD   = 6'b100100;
    localparam logic [OP_W-1:0] OP_ST   = 6'b100101;
    localparam logic [OP_W-1:0] OP_BEZ  = 6'b101000;
    localparam logic [OP_W-1:0] OP_BNE  = 6'b101001;
    localparam logic [OP_W-1:0] OP_JMP  = 6'b101010;

    // ALU commands (0 = no operation)
    localparam logic [ALU_W-1:0] ALU_NONE = 4'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd4;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SLA  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd9;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd10;

    // ID/EX pipeline register payload
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] dest;
        logic [ALU_W-1:0]  alu_cmd;
        logic              wb_en;
        logic              mem_r;
        logic              mem_w;
        logic              is_imm;
    } idex_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Purpose: bundles the IF/ID inputs, WB/MEM feedback, fetch control and the
//   ID/EX outputs of the decode stage.
// Modports: master = the surrounding pipeline (drives IF/ID, WB, MEM),
//           slave  = id_stage (drives fetch control and ID/EX).
interface id_stage_if;
    import id_stage_pkg::*;

    logic [DATA_W-1:0] PC;
    logic [DATA_W-1:0] instruction;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_value;
    logic              mem_wb_en;
    logic [ADDR_W-1:0] mem_dest;

    logic              BrTaken;
    logic [DATA_W-1:0] BrAdder;
    logic              flush;
    logic              freeze;

    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_val1;
    logic [DATA_W-1:0] ex_val2;
    logic [DATA_W-1:0] ex_imm;
    logic [ADDR_W-1:0] ex_dest;
    logic [ALU_W-1:0]  ex_alu_cmd;
    logic              ex_wb_en;
    logic              ex_mem_r;
    logic              ex_mem_w;
    logic              ex_is_imm;

    modport master (
        output PC, instruction, wb_en, wb_dest, wb_value, mem_wb_en, mem_dest,
        input  BrTaken, BrAdder, flush, freeze,
        input  ex_pc, ex_val1, ex_val2, ex_imm, ex_dest, ex_alu_cmd,
        input  ex_wb_en, ex_mem_r, ex_mem_w, ex_is_imm
    );

    modport slave (
        input  PC, instruction, wb_en, wb_dest, wb_value, mem_wb_en, mem_dest,
        output BrTaken, BrAdder, flush, freeze,
        output ex_pc, ex_val1, ex_val2, ex_imm, ex_dest, ex_alu_cmd,
        output ex_wb_en, ex_mem_r, ex_mem_w, ex_is_imm
    );

endinterface

// File: rtl/id_stage_reg_file.sv
// Purpose: 32x32 register file, r0 hardwired to zero, two async read ports,
//   one write port at the clock edge, with write-to-read bypass.
// Ports: clk, rst (sync, active-high), raddr1/raddr2 -> rdata1/rdata2,
//   we/waddr/wdata write port.
module id_stage_reg_file
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem_q [REG_COUNT];
    logic [DATA_W-1:0] mem_d [REG_COUNT];

    // Next-state: writes to r0 are dropped so entry 0 stays zero
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads: r0 is constant zero; a same-cycle WB write is forwarded
    assign rdata1 = (raddr1 == '0)              ? '0    :
                    (we && (waddr == raddr1))   ? wdata : mem_q[raddr1];
    assign rdata2 = (raddr2 == '0)              ? '0    :
                    (we && (waddr == raddr2))   ? wdata : mem_q[raddr2];

endmodule

// File: rtl/id_stage.sv
// Purpose: decode stage. Decodes the IF/ID instruction, reads the register
//   file, detects RAW hazards against EX and MEM producers, resolves
//   BEZ/BNE/JMP and registers the decoded fields into ID/EX.
// Ports: clk, rst (sync, active-high), bus (id_stage_if.slave):
//   in : PC, instruction, wb_en/wb_dest/wb_value, mem_wb_en/mem_dest
//   out: BrTaken, BrAdder, flush, freeze (combinational), ex_* (registered)
module id_stage
    import id_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);

    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] rdst;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;

    // Decoded controls
    logic [ALU_W-1:0]  dec_alu_cmd;
    logic [ADDR_W-1:0] dec_dest;
    logic              dec_wb_en;
    logic              dec_mem_r;
    logic              dec_mem_w;
    logic              dec_is_imm;
    logic              use_src1;
    logic              use_src2;
    logic              is_bez;
    logic              is_bne;
    logic              is_jmp;

    logic              hazard1;
    logic              hazard2;
    logic              freeze_int;
    logic              br_cond;
    logic              br_taken_int;

    idex_t             idex_q;
    idex_t             idex_d;

    assign op      = bus.instruction[OP_MSB:OP_LSB];
    assign src1    = bus.instruction[SRC1_MSB:SRC1_LSB];
    assign src2    = bus.instruction[SRC2_MSB:SRC2_LSB];
    assign rdst    = bus.instruction[RDST_MSB:RDST_LSB];
    assign imm_ext = sext_imm(bus.instruction[IMM_MSB:IMM_LSB]);

    id_stage_reg_file u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (src1),
        .raddr2 (src2),
        .rdata1 (val1),
        .rdata2 (val2),
        .we     (bus.wb_en),
        .waddr  (bus.wb_dest),
        .wdata  (bus.wb_value)
    );

    // Opcode decode; unknown opcodes fall through as NOP
    always_comb begin
        dec_alu_cmd = ALU_NONE;
        dec_dest    = '0;
        dec_wb_en   = 1'b0;
        dec_mem_r   = 1'b0;
        dec_mem_w   = 1'b0;
        dec_is_imm  = 1'b0;
        use_src1    = 1'b0;
        use_src2    = 1'b0;
        is_bez      = 1'b0;
        is_bne      = 1'b0;
        is_jmp      = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
            OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
                use_src1  = 1'b1;
                use_src2  = 1'b1;
                dec_wb_en = 1'b1;
                dec_dest  = rdst;
                case (op)
                    OP_ADD:  dec_alu_cmd = ALU_ADD;
                    OP_SUB:  dec_alu_cmd = ALU_SUB;
                    OP_AND:  dec_alu_cmd = ALU_AND;
                    OP_OR:   dec_alu_cmd = ALU_OR;
                    OP_NOR:  dec_alu_cmd = ALU_NOR;
                    OP_XOR:  dec_alu_cmd = ALU_XOR;
                    OP_SLA:  dec_alu_cmd = ALU_SLA;
                    OP_SLL:  dec_alu_cmd = ALU_SLL;
                    OP_SRA:  dec_alu_cmd = ALU_SRA;
                    default: dec_alu_cmd = ALU_SRL;
                endcase
            end
            OP_ADDI, OP_SUBI: begin
                use_src1    = 1'b1;
                dec_wb_en   = 1'b1;
                dec_is_imm  = 1'b1;
                dec_dest    = src2;
                dec_alu_cmd = (op == OP_ADDI) ? ALU_ADD : ALU_SUB;
            end
            OP_LD: begin
                use_src1    = 1'b1;
                dec_wb_en   = 1'b1;
                dec_mem_r   = 1'b1;
                dec_is_imm  = 1'b1;
                dec_dest    = src2;
                dec_alu_cmd = ALU_ADD;
            end
            OP_ST: begin
                use_src1    = 1'b1;
                use_src2    = 1'b1;
                dec_mem_w   = 1'b1;
                dec_is_imm  = 1'b1;
                dec_dest    = src2;
                dec_alu_cmd = ALU_ADD;
            end
            OP_BEZ: begin
                use_src1 = 1'b1;
                is_bez   = 1'b1;
            end
            OP_BNE: begin
                use_src1 = 1'b1;
                use_src2 = 1'b1;
                is_bne   = 1'b1;
            end
            OP_JMP: begin
                is_jmp = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // RAW hazard against the EX (ID/EX register) and MEM producers; r0 is exempt
    assign hazard1 = use_src1 && (src1 != '0) &&
                     ((idex_q.wb_en && (src1 == idex_q.dest)) ||
                      (bus.mem_wb_en && (src1 == bus.mem_dest)));
    assign hazard2 = use_src2 && (src2 != '0) &&
                     ((idex_q.wb_en && (src2 == idex_q.dest)) ||
                      (bus.mem_wb_en && (src2 == bus.mem_dest)));

    // Reset suppresses any pending stall or redirect
    assign freeze_int   = !rst && (hazard1 || hazard2);
    assign br_cond      = (is_bez && (val1 == '0)) ||
                          (is_bne && (val1 != val2)) ||
                          is_jmp;
    assign br_taken_int = !rst && !freeze_int && br_cond;

    assign bus.freeze  = freeze_int;
    assign bus.BrTaken = br_taken_int;
    assign bus.flush   = br_taken_int;
    assign bus.BrAdder = bus.PC + {imm_ext[DATA_W-3:0], 2'b00};

    // ID/EX next value: bubble while frozen
    always_comb begin
        idex_d = '0;
        if (!freeze_int) begin
            idex_d.pc      = bus.PC;
            idex_d.val1    = val1;
            idex_d.val2    = val2;
            idex_d.imm     = imm_ext;
            idex_d.dest    = dec_dest;
            idex_d.alu_cmd = dec_alu_cmd;
            idex_d.wb_en   = dec_wb_en;
            idex_d.mem_r   = dec_mem_r;
            idex_d.mem_w   = dec_mem_w;
            idex_d.is_imm  = dec_is_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.ex_pc      = idex_q.pc;
    assign bus.ex_val1    = idex_q.val1;
    assign bus.ex_val2    = idex_q.val2;
    assign bus.ex_imm     = idex_q.imm;
    assign bus.ex_dest    = idex_q.dest;
    assign bus.ex_alu_cmd = idex_q.alu_cmd;
    assign bus.ex_wb_en   = idex_q.wb_en;
    assign bus.ex_mem_r   = idex_q.mem_r;
    assign bus.ex_mem_w   = idex_q.mem_w;
    assign bus.ex_is_imm  = idex_q.is_imm;

endmodule

// File: tb/tb_id_stage.sv
// Purpose: self-checking bench for id_stage. Inputs change on the falling
//   edge; combinational outputs are checked 1 ns later and ID/EX 1 ns after
//   the following rising edge.
module tb_id_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wb_en;
        logic [4:0]  wb_dest;
        logic [31:0] wb_value;
        logic        mem_wb_en;
        logic [4:0]  mem_dest;
        logic        e_freeze;
        logic        e_br;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_val1;
        logic [31:0] e_val2;
        logic [31:0] e_imm;
        logic [4:0]  e_dest;
        logic [3:0]  e_alu;
        logic [3:0]  e_ctrl;   // {wb_en, mem_r, mem_w, is_imm}
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [15:0] lo);
        return {op, s1, s2, lo};
    endfunction

    function automatic vec_t mk(
        input logic [31:0] instr, input logic [31:0] pc,
        input logic wb_en, input logic [4:0] wb_dest, input logic [31:0] wb_value,
        input logic mem_wb_en, input logic [4:0] mem_dest,
        input logic e_freeze, input logic e_br, input logic [31:0] e_addr,
        input logic [31:0] e_pc, input logic [31:0] e_val1, input logic [31:0] e_val2,
        input logic [31:0] e_imm, input logic [4:0] e_dest, input logic [3:0] e_alu,
        input logic [3:0] e_ctrl);
        vec_t v;
        v.instr = instr;       v.pc = pc;
        v.wb_en = wb_en;       v.wb_dest = wb_dest;     v.wb_value = wb_value;
        v.mem_wb_en = mem_wb_en; v.mem_dest = mem_dest;
        v.e_freeze = e_freeze; v.e_br = e_br;           v.e_addr = e_addr;
        v.e_pc = e_pc;         v.e_val1 = e_val1;       v.e_val2 = e_val2;
        v.e_imm = e_imm;       v.e_dest = e_dest;       v.e_alu = e_alu;
        v.e_ctrl = e_ctrl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic wb_en, input logic [4:0] wb_dest, input logic [31:0] wb_value,
                         input logic mem_wb_en, input logic [4:0] mem_dest);
        bus.instruction = instr;
        bus.PC          = pc;
        bus.wb_en       = wb_en;
        bus.wb_dest     = wb_dest;
        bus.wb_value    = wb_value;
        bus.mem_wb_en   = mem_wb_en;
        bus.mem_dest    = mem_dest;
    endtask

    task automatic check_ex(input string tag, input vec_t v);
        chk({tag, " ex_pc"},      bus.ex_pc,      v.e_pc);
        chk({tag, " ex_val1"},    bus.ex_val1,    v.e_val1);
        chk({tag, " ex_val2"},    bus.ex_val2,    v.e_val2);
        chk({tag, " ex_imm"},     bus.ex_imm,     v.e_imm);
        chk({tag, " ex_dest"},    32'(bus.ex_dest),    32'(v.e_dest));
        chk({tag, " ex_alu_cmd"}, 32'(bus.ex_alu_cmd), 32'(v.e_alu));
        chk({tag, " ex_ctrl"},
            32'({bus.ex_wb_en, bus.ex_mem_r, bus.ex_mem_w, bus.ex_is_imm}),
            32'(v.e_ctrl));
    endtask

    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(v.instr, v.pc, v.wb_en, v.wb_dest, v.wb_value, v.mem_wb_en, v.mem_dest);
        #1;
        chk({tag, " freeze"},  32'(bus.freeze),  32'(v.e_freeze));
        chk({tag, " BrTaken"}, 32'(bus.BrTaken), 32'(v.e_br));
        chk({tag, " flush"},   32'(bus.flush),   32'(v.e_br));
        chk({tag, " BrAdder"}, bus.BrAdder,      v.e_addr);
        @(posedge clk);
        #1;
        check_ex(tag, v);
    endtask

    initial begin
        vec_t zero_v;
        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            instr                            pc          wb            mem       frz br addr          ex_pc       val1         val2         imm          dst alu ctrl
        vecs[0]  = mk(enc(6'h20, 0, 1, 16'd1546),      32'h4,      0, 0, 0,      0, 0,     0, 0, 32'h182C,    32'h4,      0,           0,           32'h60A,     1,  1,  4'b1001);
        vecs[1]  = mk(32'h0,                           32'h8,      0, 0, 0,      0, 0,     0, 0, 32'h8,       32'h8,      0,           0,           0,           0,  0,  4'b0000);
        vecs[2]  = mk(enc(6'h01, 2, 1, {5'd3, 11'd0}), 32'hC,      1, 2, 32'h1234, 0, 0,   0, 0, 32'h600C,    32'hC,      32'h1234,    0,           32'h1800,    3,  1,  4'b1000);
        vecs[3]  = mk(enc(6'h01, 0, 1, {5'd3, 11'd0}), 32'h10,     1, 0, 32'h5555, 0, 0,   0, 0, 32'h6010,    32'h10,     0,           0,           32'h1800,    3,  1,  4'b1000);
        vecs[4]  = mk(enc(6'h24, 2, 5, 16'h0),         32'h14,     0, 0, 0,      0, 0,     0, 0, 32'h14,      32'h14,     32'h1234,    0,           0,           5,  1,  4'b1101);
        vecs[5]  = mk(enc(6'h28, 5, 0, 16'h1),         32'h34,     0, 0, 0,      0, 0,     1, 0, 32'h38,      0,          0,           0,           0,           0,  0,  4'b0000);
        vecs[6]  = mk(enc(6'h28, 5, 0, 16'h1),         32'h34,     0, 0, 0,      1, 5,     1, 0, 32'h38,      0,          0,           0,           0,           0,  0,  4'b0000);
        vecs[7]  = mk(enc(6'h28, 5, 0, 16'h1),         32'h34,     1, 5, 0,      0, 0,     0, 1, 32'h38,      32'h34,     0,           0,           1,           0,  0,  4'b0000);
        vecs[8]  = mk(enc(6'h29, 1, 3, 16'h8),         32'h40,     0, 0, 0,      0, 0,     0, 0, 32'h60,      32'h40,     0,           0,           8,           0,  0,  4'b0000);
        vecs[9]  = mk(enc(6'h29, 2, 1, 16'hFFFE),      32'h50,     0, 0, 0,      0, 0,     0, 1, 32'h48,      32'h50,     32'h1234,    0,           32'hFFFFFFFE, 0, 0,  4'b0000);
        vecs[10] = mk(enc(6'h2A, 0, 0, 16'hFFFF),      32'h100,    0, 0, 0,      0, 0,     0, 1, 32'hFC,      32'h100,    0,           0,           32'hFFFFFFFF, 0, 0,  4'b0000);
        vecs[11] = mk(enc(6'h2A, 5, 0, 16'hFFFF),      32'h0,      0, 0, 0,      1, 5,     0, 1, 32'hFFFFFFFC, 32'h0,     0,           0,           32'hFFFFFFFF, 0, 0,  4'b0000);
        vecs[12] = mk(enc(6'h3F, 2, 0, {5'd7, 11'd0}), 32'h60,     0, 0, 0,      1, 2,     0, 0, 32'hE060,    32'h60,     32'h1234,    0,           32'h3800,    0,  0,  4'b0000);
        vecs[13] = mk(enc(6'h21, 2, 4, 16'hFFFD),      32'h70,     0, 0, 0,      0, 0,     0, 0, 32'h64,      32'h70,     32'h1234,    0,           32'hFFFFFFFD, 4, 2,  4'b1001);
        vecs[14] = mk(enc(6'h25, 2, 4, 16'h4),         32'h74,     0, 0, 0,      0, 0,     1, 0, 32'h84,      0,          0,           0,           0,           0,  0,  4'b0000);
        vecs[15] = mk(enc(6'h25, 2, 4, 16'h4),         32'h74,     1, 4, 32'hCAFE, 0, 0,   0, 0, 32'h84,      32'h74,     32'h1234,    32'hCAFE,    4,           4,  1,  4'b0011);
        vecs[16] = mk(enc(6'h08, 4, 2, {5'd6, 11'd0}), 32'h78,     0, 0, 0,      0, 0,     0, 0, 32'hC078,    32'h78,     32'hCAFE,    32'h1234,    32'h3000,    6,  6,  4'b1000);
        vecs[17] = mk(enc(6'h0C, 6, 0, {5'd7, 11'd0}), 32'h7C,     0, 0, 0,      0, 0,     1, 0, 32'hE07C,    0,          0,           0,           0,           0,  0,  4'b0000);
        vecs[18] = mk(enc(6'h0C, 6, 0, {5'd7, 11'd0}), 32'h7C,     1, 6, 32'hF0, 0, 0,     0, 0, 32'hE07C,    32'h7C,     32'hF0,      0,           32'h3800,    7,  10, 4'b1000);

        // Reset with a JMP presented: no redirect, ID/EX cleared
        rst = 1'b1;
        drive(enc(6'h2A, 0, 0, 16'h4), 32'h20, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst BrTaken", 32'(bus.BrTaken), 0);
        chk("rst flush",   32'(bus.flush),   0);
        chk("rst freeze",  32'(bus.freeze),  0);
        check_ex("rst", zero_v);

        // r1..r31 read zero after reset (ADD r0, rk, r0)
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k < 32; k++) begin
            if (k > 1) @(negedge clk);
            drive(enc(6'h01, 5'(k), 0, 16'h0), 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("r%0d freeze", k), 32'(bus.freeze), 0);
            @(posedge clk);
            #1;
            chk($sformatf("r%0d reset value", k), bus.ex_val1, 0);
        end

        for (int i = 0; i < NVEC; i++) begin
            apply(i, vecs[i]);
        end

        // Reset while a stall is pending; register file must be cleared
        @(negedge clk);
        drive(enc(6'h24, 0, 2, 16'h0), 32'h200, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(enc(6'h28, 2, 0, 16'h1), 32'h34, 0, 0, 0, 0, 0);
        #1;
        chk("mid freeze pre-rst", 32'(bus.freeze), 1);
        rst = 1'b1;
        #1;
        chk("mid freeze in rst",  32'(bus.freeze),  0);
        chk("mid BrTaken in rst", 32'(bus.BrTaken), 0);
        @(posedge clk);
        #1;
        chk("mid ex_wb_en", 32'(bus.ex_wb_en), 0);
        chk("mid ex_pc",    bus.ex_pc,         0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post freeze",  32'(bus.freeze),  0);
        chk("post BrTaken", 32'(bus.BrTaken), 1);
        chk("post BrAdder", bus.BrAdder,      32'h38);
        @(posedge clk);
        #1;
        chk("post ex_pc",   bus.ex_pc,   32'h34);
        chk("post ex_val1", bus.ex_val1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
